// File: rtl/d16_mem_pkg.sv
// d16_mem_pkg: types shared by the 16-bit memory arbiter and its bench.
// Holds the FSM state enum, grant encoding, request bundle and memory depth.
package d16_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  typedef struct packed {
    logic        we;
    logic        byte_en;
    logic        byte_sel;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_req_t;

  localparam int MEM_WORDS = 64;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) arbiter onto one 16-bit memory port.
// Ports: clk, rst (sync, active-high); fetch if_req/if_addr -> if_ack/if_rdata;
// data d_req/d_we/d_byte_en/d_byte_sel/d_addr/d_wdata -> d_ack/d_rdata;
// memory mem_en/mem_we/mem_byte_en/mem_byte_sel/mem_addr/mem_wdata,
// mem_rdata (registered, valid the cycle after mem_en), mem_wait (stall).
// Build option: MEM_ARB_RR_EN selects round-robin arbitration on contention;
// undefined gives fixed priority to the data port.
module mem_arbiter
  import d16_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte_en,
  input  logic        d_byte_sel,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic        mem_byte_en,
  output logic        mem_byte_sel,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_wait
);

  state_t      r_state;
  state_t      w_next;
  gnt_t        r_gnt;
  gnt_t        w_gnt;
  mem_req_t    r_req;
  mem_req_t    w_req;
  logic [15:0] r_if_rdata;
  logic [15:0] r_d_rdata;
  logic        w_grant;
  logic        w_access;
  logic        w_resp;

  assign w_grant = (r_state == IDLE) && (if_req || d_req);

`ifdef MEM_ARB_RR_EN
  // Set means the data port wins the next contested grant.
  logic r_prio_d;

  always_comb begin
    w_gnt = d_req ? GNT_D : GNT_IF;
    if (if_req && d_req)
      w_gnt = r_prio_d ? GNT_D : GNT_IF;
  end

  // Only contested grants move the pointer; the loser gets priority.
  always_ff @(posedge clk) begin
    if (rst)
      r_prio_d <= 1'b1;
    else if (w_grant && if_req && d_req)
      r_prio_d <= (w_gnt == GNT_IF);
  end
`else
  always_comb w_gnt = d_req ? GNT_D : GNT_IF;
`endif

  // Fetches are plain word reads: write controls and data forced to 0.
  always_comb begin
    w_req = '0;
    if (w_gnt == GNT_D) begin
      w_req.we       = d_we;
      w_req.byte_en  = d_byte_en;
      w_req.byte_sel = d_byte_sel;
      w_req.addr     = d_addr;
      w_req.wdata    = d_wdata;
    end else begin
      w_req.addr = if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (if_req || d_req) w_next = ACCESS;
      ACCESS:  if (!mem_wait) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Fields are captured once at grant and never resampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt <= GNT_IF;
      r_req <= '0;
    end else if (w_grant) begin
      r_gnt <= w_gnt;
      r_req <= w_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (r_state == RESP) begin
      if (r_gnt == GNT_IF)
        r_if_rdata <= mem_rdata;
      else
        r_d_rdata <= mem_rdata;
    end
  end

  assign w_access = (r_state == ACCESS);
  assign w_resp   = (r_state == RESP);

  always_comb begin
    mem_en       = w_access;
    mem_we       = w_access && r_req.we;
    mem_byte_en  = w_access && r_req.byte_en;
    mem_byte_sel = w_access && r_req.byte_sel;
    mem_addr     = r_req.addr;
    mem_wdata    = r_req.wdata;
    if_ack       = w_resp && (r_gnt == GNT_IF);
    d_ack        = w_resp && (r_gnt == GNT_D);
    if_rdata     = if_ack ? mem_rdata : r_if_rdata;
    d_rdata      = d_ack ? mem_rdata : r_d_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a word-array memory and a transaction-level reference.
module tb_mem_arbiter;
  import d16_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_byte_en;
  logic        d_byte_sel;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic        mem_byte_en;
  logic        mem_byte_sel;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_wait;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] tb_mem  [MEM_WORDS];
  logic [15:0] ref_mem [MEM_WORDS];
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_byte_en(d_byte_en), .d_byte_sel(d_byte_sel),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_byte_en(mem_byte_en), .mem_byte_sel(mem_byte_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_wait(mem_wait)
  );

  // Memory: registered read-before-write, commits on the last access cycle.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < MEM_WORDS; i++)
        tb_mem[i] <= 16'h1000 + 16'(i);
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= tb_mem[mem_addr[5:0]];
      if (mem_we && !mem_wait) begin
        if (!mem_byte_en)
          tb_mem[mem_addr[5:0]] <= mem_wdata;
        else if (mem_byte_sel)
          tb_mem[mem_addr[5:0]][15:8] <= mem_wdata[7:0];
        else
          tb_mem[mem_addr[5:0]][7:0] <= mem_wdata[7:0];
      end
    end
  end

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic be, input logic sel,
                                        input logic [15:0] wd);
    if (!be) return wd;
    if (sel) return {wd[7:0], old[7:0]};
    return {old[15:8], wd[7:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_byte_en = 0; d_byte_sel = 0;
    d_addr = 0; d_wdata = 0; mem_wait = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic wait_ack(output int n, output logic gi, output logic gd);
    n = -1; gi = 0; gd = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (if_ack || d_ack) begin
        n = k; gi = if_ack; gd = d_ack;
        break;
      end
    end
  endtask

  function automatic logic [69:0] all_out();
    return {if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we,
            mem_byte_en, mem_byte_sel, mem_addr, mem_wdata};
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    n_cmp++;
    if (all_out() !== 70'h0) begin
      n_err++;
      $display("FAIL reset_outs: got %h want 0", all_out());
    end
    rst = 0;
    step();
  endtask

  task automatic test_write_read();
    int n; logic gi, gd;
    d_req = 1; d_we = 1; d_addr = 16'd5; d_wdata = 16'hBEEF;
    wait_ack(n, gi, gd);
    n_cmp++;
    if (n !== 2 || gd !== 1'b1 || gi !== 1'b0) begin
      n_err++;
      $display("FAIL wr_ack: n=%0d gi=%b gd=%b want n=2 d-ack", n, gi, gd);
    end
    ref_mem[5] = 16'hBEEF;
    d_req = 0; d_we = 0;
    if_req = 1; if_addr = 16'd5;
    wait_ack(n, gi, gd);
    n_cmp++;
    if (n !== 3 || gi !== 1'b1 || gd !== 1'b0) begin
      n_err++;
      $display("FAIL rd_ack: n=%0d gi=%b gd=%b want n=3 if-ack", n, gi, gd);
    end
    n_cmp++;
    if (if_rdata !== 16'hBEEF) begin
      n_err++;
      $display("FAIL rd_data: got %h want BEEF", if_rdata);
    end
    if_req = 0;
    step();
    n_cmp++;
    if (if_ack !== 1'b0 || if_rdata !== 16'hBEEF) begin
      n_err++;
      $display("FAIL rd_hold: ack=%b data=%h want 0 BEEF", if_ack, if_rdata);
    end
  endtask

  task automatic test_contest();
    int n; logic gi, gd; logic exp_if2;
`ifdef MEM_ARB_RR_EN
    exp_if2 = 1'b1;
`else
    exp_if2 = 1'b0;
`endif
    idle_inputs();
    do_reset();
    d_req = 1; d_addr = 16'd10;
    if_req = 1; if_addr = 16'd11;
    wait_ack(n, gi, gd);
    n_cmp++;
    if (n !== 2 || gd !== 1'b1 || gi !== 1'b0 || d_rdata !== ref_mem[10]) begin
      n_err++;
      $display("FAIL contest1_d: n=%0d gi=%b gd=%b rd=%h want 2 d %h",
               n, gi, gd, d_rdata, ref_mem[10]);
    end
    d_req = 0;
    wait_ack(n, gi, gd);
    n_cmp++;
    if (n !== 3 || gi !== 1'b1 || if_rdata !== ref_mem[11]) begin
      n_err++;
      $display("FAIL contest1_if: n=%0d gi=%b rd=%h want 3 if %h",
               n, gi, if_rdata, ref_mem[11]);
    end
    if_req = 0;
    step();
    d_req = 1; if_req = 1;
    wait_ack(n, gi, gd);
    n_cmp++;
    if (n !== 2 || gi !== exp_if2 || gd !== !exp_if2) begin
      n_err++;
      $display("FAIL contest2_win: n=%0d gi=%b gd=%b want 2 gi=%b",
               n, gi, gd, exp_if2);
    end
    if (gi) if_req = 0;
    if (gd) d_req = 0;
    wait_ack(n, gi, gd);
    n_cmp++;
    if (n !== 3 || gi !== !exp_if2 || gd !== exp_if2) begin
      n_err++;
      $display("FAIL contest2_lose: n=%0d gi=%b gd=%b want 3 gi=%b",
               n, gi, gd, !exp_if2);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_wait();
    d_req = 1; d_we = 0; d_addr = 16'd7; mem_wait = 1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++;
      if (mem_en !== 1'b1 || mem_addr !== 16'd7 || d_ack !== 1'b0) begin
        n_err++;
        $display("FAIL wait_hold%0d: en=%b addr=%h ack=%b want 1 0007 0",
                 k, mem_en, mem_addr, d_ack);
      end
      if (k == 3) mem_wait = 0;
    end
    step();
    n_cmp++;
    if (d_ack !== 1'b1 || d_rdata !== ref_mem[7]) begin
      n_err++;
      $display("FAIL wait_ack: ack=%b rd=%h want 1 %h", d_ack, d_rdata, ref_mem[7]);
    end
    d_req = 0;
    step();
  endtask

  task automatic test_reset_access();
    int n; logic gi, gd;
    d_req = 1; d_addr = 16'd9;
    step();
    n_cmp++;
    if (mem_en !== 1'b1) begin
      n_err++;
      $display("FAIL rsta_access: en=%b want 1", mem_en);
    end
    rst = 1; d_req = 0;
    step();
    n_cmp++;
    if (all_out() !== 70'h0) begin
      n_err++;
      $display("FAIL rsta_outs: got %h want 0", all_out());
    end
    rst = 0;
    if_req = 1; if_addr = 16'd2;
    wait_ack(n, gi, gd);
    n_cmp++;
    if (n !== 2 || gi !== 1'b1 || if_rdata !== ref_mem[2]) begin
      n_err++;
      $display("FAIL rsta_after: n=%0d gi=%b rd=%h want 2 1 %h",
               n, gi, if_rdata, ref_mem[2]);
    end
    if_req = 0;
    step();
  endtask

  task automatic test_byte();
    d_req = 1; d_we = 1; d_byte_en = 1; d_byte_sel = 1;
    d_addr = 16'd3; d_wdata = 16'h00AA;
    step();
    n_cmp++;
    if ({mem_en, mem_we, mem_byte_en, mem_byte_sel, mem_addr, mem_wdata}
        !== {4'b1111, 16'd3, 16'h00AA}) begin
      n_err++;
      $display("FAIL byte_ctl: en=%b we=%b be=%b sel=%b a=%h wd=%h",
               mem_en, mem_we, mem_byte_en, mem_byte_sel, mem_addr, mem_wdata);
    end
    step();
    n_cmp++;
    if (d_ack !== 1'b1) begin
      n_err++;
      $display("FAIL byte_ack: ack=%b want 1", d_ack);
    end
    ref_mem[3] = merge(ref_mem[3], 1'b1, 1'b1, 16'h00AA);
    d_req = 0; d_we = 0; d_byte_en = 0; d_byte_sel = 0;
    if_req = 1; if_addr = 16'd3;
    step(); step();
    n_cmp++;
    if ({mem_en, mem_we, mem_byte_en, mem_addr, mem_wdata}
        !== {3'b100, 16'd3, 16'h0}) begin
      n_err++;
      $display("FAIL fetch_ctl: en=%b we=%b be=%b a=%h wd=%h want 1 0 0 0003 0",
               mem_en, mem_we, mem_byte_en, mem_addr, mem_wdata);
    end
    step();
    n_cmp++;
    if (if_ack !== 1'b1 || if_rdata !== ref_mem[3]) begin
      n_err++;
      $display("FAIL byte_rd: ack=%b rd=%h want 1 %h", if_ack, if_rdata, ref_mem[3]);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_drop();
    int acks; int ens; int first;
    d_req = 1; d_addr = 16'd4;
    step();
    d_req = 0;
    acks = 0; ens = int'(mem_en); first = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (d_ack && first < 0) first = k;
      acks += int'(d_ack);
      ens += int'(mem_en);
    end
    n_cmp++;
    if (acks !== 1 || ens !== 1 || first !== 1) begin
      n_err++;
      $display("FAIL drop: acks=%0d ens=%0d at=%0d want 1 1 1", acks, ens, first);
    end
  endtask

  task automatic test_random();
    logic if_pend, d_pend, d_w, d_be, d_sel;
    logic [15:0] if_a, d_a, d_wd, last_if, last_d, exp;
    int if_lat, d_lat;
    logic aborted;
    idle_inputs();
    do_reset();
    if_pend = 0; d_pend = 0; last_if = 0; last_d = 0;
    if_lat = 0; d_lat = 0; aborted = 0;
    d_w = 0; d_be = 0; d_sel = 0; if_a = 0; d_a = 0; d_wd = 0;
    for (int it = 0; it < 500 && !aborted; it++) begin
      logic just_if, just_d;
      step();
      if (if_pend) if_lat++;
      if (d_pend) d_lat++;
      just_if = 0; just_d = 0;
      n_cmp++;
      if (if_ack && d_ack) begin
        n_err++;
        $display("FAIL rnd_both_ack at it=%0d", it);
      end
      if (if_ack) begin
        exp = ref_mem[if_a[5:0]];
        n_cmp++;
        if (!if_pend || if_lat < 2 || if_rdata !== exp) begin
          n_err++;
          $display("FAIL rnd_if: pend=%b lat=%0d rd=%h want %h",
                   if_pend, if_lat, if_rdata, exp);
        end
        last_if = exp; if_pend = 0; if_req = 0; just_if = 1;
      end else begin
        n_cmp++;
        if (if_rdata !== last_if) begin
          n_err++;
          $display("FAIL rnd_if_hold: rd=%h want %h", if_rdata, last_if);
        end
      end
      if (d_ack) begin
        exp = ref_mem[d_a[5:0]];
        n_cmp++;
        if (!d_pend || d_lat < 2 || d_rdata !== exp) begin
          n_err++;
          $display("FAIL rnd_d: pend=%b lat=%0d rd=%h want %h",
                   d_pend, d_lat, d_rdata, exp);
        end
        if (d_w) ref_mem[d_a[5:0]] = merge(exp, d_be, d_sel, d_wd);
        last_d = exp; d_pend = 0; d_req = 0; just_d = 1;
      end else begin
        n_cmp++;
        if (d_rdata !== last_d) begin
          n_err++;
          $display("FAIL rnd_d_hold: rd=%h want %h", d_rdata, last_d);
        end
      end
      if (if_lat > 40 || d_lat > 40) begin
        n_err++;
        $display("FAIL rnd_timeout: if_lat=%0d d_lat=%0d", if_lat, d_lat);
        aborted = 1;
      end
      if (it < 420 && !if_pend && !just_if && $urandom_range(0, 2) == 0) begin
        if_a = 16'($urandom);
        if_addr = if_a; if_req = 1; if_pend = 1; if_lat = 0;
      end
      if (it < 420 && !d_pend && !just_d && $urandom_range(0, 2) == 0) begin
        d_a = 16'($urandom); d_wd = 16'($urandom);
        d_w = 1'($urandom); d_be = 1'($urandom); d_sel = 1'($urandom);
        d_addr = d_a; d_wdata = d_wd; d_we = d_w;
        d_byte_en = d_be; d_byte_sel = d_sel;
        d_req = 1; d_pend = 1; d_lat = 0;
      end
      mem_wait = ($urandom_range(0, 3) == 0);
    end
    n_cmp++;
    if (if_pend || d_pend) begin
      n_err++;
      $display("FAIL rnd_drain: if_pend=%b d_pend=%b", if_pend, d_pend);
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++)
      ref_mem[i] = 16'h1000 + 16'(i);
    idle_inputs();
    rst = 1;
    step(); step();
    test_reset();
    test_write_read();
    test_contest();
    test_wait();
    test_reset_access();
    test_byte();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 if_req  in  1  fetch requester read request; held high until if_ack.
REQ-004 if_addr  in  16  fetch word address.
REQ-005 if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle.
REQ-006 if_rdata  out  16  fetch read data.
REQ-007 d_req  in  1  data requester request; held high until d_ack.
REQ-008 d_we, d_byte_en, d_byte_sel  in  1 each  write enable, byte-mode enable, high-byte select.
REQ-009 d_addr, d_wdata  in  16 each  data address, write data.
REQ-010 d_ack  out  1  one-cycle completion pulse, for reads and writes.
REQ-011 d_rdata  out  16  data read data, valid with d_ack.
REQ-012 mem_en, mem_we, mem_byte_en, mem_byte_sel  out  1 each  memory port controls.
REQ-013 mem_addr, mem_wdata  out  16 each  memory address and write data.
REQ-014 mem_rdata  in  16  registered memory read data, valid one cycle after the mem_en cycle.
REQ-015 mem_wait  in  1  memory stall; extends the access cycle while high.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-017 IDLE: if either request is high, the FSM SHALL select a winner, latch the winner's address, controls and wdata, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-018 ACCESS: mem_en SHALL be 1 and the memory outputs SHALL carry the latched fields; a fetch access SHALL drive mem_we=0, mem_byte_en=0 and mem_wdata=0.
REQ-019 ACCESS with mem_wait=1: the FSM SHALL stay in ACCESS with all outputs unchanged; with mem_wait=0 it SHALL go to RESP.
REQ-020 RESP: the FSM SHALL pulse the winner's ack for exactly one cycle, drive that requester's rdata from mem_rdata, drive mem_en=0, and return to IDLE.
REQ-021 Latency from request sampled in IDLE to ack SHALL be 2 cycles plus one cycle per mem_wait stall cycle.
REQ-022 Back-to-back requests SHALL have a minimum spacing of 3 cycles per transaction; the IDLE cycle after RESP is mandatory.
REQ-023 A granted transaction SHALL complete even if its req drops after grant; the request fields SHALL NOT be resampled after grant.
REQ-024 On simultaneous if_req and d_req, the winner SHALL follow the Configuration rule; the loser keeps its request and is served on the next IDLE.
REQ-025 if_rdata and d_rdata SHALL hold their last value outside ack cycles; the non-winner's rdata SHALL NOT change.
REQ-026 Write data SHALL be passed through unmodified; byte lane placement is the memory's job.

Reset
REQ-027 rst=1 SHALL force IDLE and clear every output to 0 (acks, rdata, mem_* controls, address and wdata) on the next edge; an in-flight transaction SHALL be aborted with no ack.
REQ-028 The round-robin pointer SHALL reset to favour the data port.

Configuration
REQ-029 MEM_ARB_RR_EN defined: round-robin; after a contested grant, the loser gets priority at the next contested IDLE.
REQ-030 MEM_ARB_RR_EN undefined: fixed priority; the data port always wins contention, and the pointer register is absent.

Structure
REQ-031 A shared package d16_mem_pkg SHALL hold the FSM state enum (IDLE/ACCESS/RESP), the grant encoding (GNT_IF, GNT_D) and MEM_WORDS=64.
REQ-032 No sub-module: winner selection SHALL be inline logic.

Verification
REQ-033 d_req write to addr 5 with data 16'hBEEF, then fetch of addr 5 -> d_ack 2 cycles after request, if_rdata=16'hBEEF with if_ack 3 cycles later.
REQ-034 if_req and d_req both asserted in the same cycle, fixed priority -> d_ack first, if_ack 3 cycles after d_ack; in RR mode, a second contest is won by fetch.
REQ-035 mem_wait held high for 2 cycles during ACCESS -> mem_addr stable throughout, ack at cycle 4.
REQ-036 rst asserted in ACCESS cycle -> no ack, all outputs 0 next cycle, new request served normally.
REQ-037 Byte write with d_byte_en=1, d_byte_sel=1, d_wdata=16'h00AA to addr 3 -> mem_byte_en=1, mem_byte_sel=1, mem_wdata=16'h00AA during ACCESS.
REQ-038 d_req dropped the cycle after grant -> d_ack still pulses once, no second access.
